multi_digit_counter: RTL

- Parametrised N-digit modulo-RADIX (default BCD) counter for the dual-slope ADC conversion path.
- Counts clock pulses during the de-integration phase and supports up/down counting and parallel preload.
- Provides a carry/borrow output for cascading and a sticky wrap flag.
- Holds a separate output latch so the display/readout keeps the previous result while the next conversion counts.

---
 rtl/adc_counter_pkg.sv | 16 +
 rtl/counter_digit.sv | 48 ++++
 rtl/multi_digit_counter.sv | 72 +++++++
 3 files changed

// File: rtl/adc_counter_pkg.sv
// Shared types and helpers for the dual-slope ADC counter path.
// Digit width derivation and count-direction encoding.
package adc_counter_pkg;

    localparam int DEFAULT_RADIX = 10;

    typedef enum logic {
        DN = 1'b0,
        UP = 1'b1
    } cnt_dir_t;

    function automatic int digit_width(input int radix);
        return $clog2(radix);
    endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-RADIX digit with clamped preload and local wrap.
// Stepping is gated by the top level's carry/borrow chain.
module counter_digit
    import adc_counter_pkg::*;
#(
    parameter int RADIX = DEFAULT_RADIX,
    parameter int DW    = digit_width(RADIX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] load_digit,
    input  logic          step_en,
    input  logic          up_dn,
    output logic [DW-1:0] digit,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW-1:0] MAX = DW'(RADIX - 1);
    localparam logic [DW:0]   LIM = (DW+1)'(RADIX);

    cnt_dir_t      dir;
    logic [DW-1:0] ld_clamped;

    assign dir        = cnt_dir_t'(up_dn);
    assign at_max     = (digit == MAX);
    assign at_min     = (digit == '0);
    // Out-of-range preload fields saturate to the top digit value
    assign ld_clamped = ({1'b0, load_digit} >= LIM) ? MAX : load_digit;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (load) begin
            digit <= ld_clamped;
        end else if (step_en) begin
            if (dir == UP)
                digit <= at_max ? '0 : digit + DW'(1);
            else
                digit <= at_min ? MAX : digit - DW'(1);
        end
    end

endmodule

// File: rtl/multi_digit_counter.sv
// N-digit modulo-RADIX up/down counter with preload, sticky wrap
// and a readout latch that captures the pre-update count.
module multi_digit_counter
    import adc_counter_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int RADIX  = DEFAULT_RADIX,
    localparam int DW     = digit_width(RADIX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 enb,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    input  logic                 lat_en,
    output logic [DIGITS*DW-1:0] q,
    output logic [DIGITS*DW-1:0] q_lat,
    output logic                 carry_out,
    output logic                 wrap
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] step_en;
    logic [DIGITS:0]   max_ch;
    logic [DIGITS:0]   min_ch;

    assign max_ch[0] = 1'b1;
    assign min_ch[0] = 1'b1;

    // Digit i steps only when every lower digit is at its extreme
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        assign max_ch[i+1] = max_ch[i] & at_max[i];
        assign min_ch[i+1] = min_ch[i] & at_min[i];
        assign step_en[i]  = enb & (up_dn ? max_ch[i] : min_ch[i]);

        counter_digit #(
            .RADIX (RADIX),
            .DW    (DW)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .load       (load),
            .load_digit (load_val[i*DW +: DW]),
            .step_en    (step_en[i]),
            .up_dn      (up_dn),
            .digit      (q[i*DW +: DW]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
        );
    end

    assign carry_out = enb & (up_dn ? max_ch[DIGITS] : min_ch[DIGITS]);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wrap  <= 1'b0;
            q_lat <= '0;
        end else begin
            if (lat_en)
                q_lat <= q;
            if (clr)
                wrap <= 1'b0;
            else if (!load && carry_out)
                wrap <= 1'b1;
        end
    end

endmodule
